// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, state encodings and helpers for the LCD text driver
package lcd_pkg;

    localparam int TEXT_W = 257;

    // Write-path handshake: writer done -> top advance -> top start -> writer accepts
    localparam int HANDSHAKE_CYC = 3;

    localparam logic [7:0] LCD_FUNC_SET = 8'h28;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    typedef enum logic [7:0] {
        POWERUP   = 8'b0000_0001,
        INIT      = 8'b0000_0010,
        LATCH     = 8'b0000_0100,
        ADDR1     = 8'b0000_1000,
        LINE1     = 8'b0001_0000,
        ADDR2     = 8'b0010_0000,
        LINE2     = 8'b0100_0000,
        FRAME_END = 8'b1000_0000
    } lcd_state_t;

    typedef enum logic [1:0] {
        W_IDLE, W_SETUP, W_PULSE, W_HOLD
    } wr_phase_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_ENTRY;
            2'd2:    return LCD_DISP_ON;
            default: return LCD_CLEAR;
        endcase
    endfunction

    function automatic logic [7:0] char_at(input logic [255:0] t, input logic [4:0] i);
        return t[8*(31 - int'(i)) +: 8];
    endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// rtl/lcd_nibble_writer.sv - one 4-bit LCD write: setup, E pulse, hold, done
// done leads the end of the hold by HANDSHAKE_CYC so the next DB change lands exactly post_wait after E falls; post_wait >= 4.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int E_PULSE_CYC = 12
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        rs,
    input  logic [3:0]  nibble,
    input  logic [31:0] post_wait,
    output logic        done,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic [3:0]  lcd_db
);

    wr_phase_t   phase;
    logic [31:0] cnt;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            phase  <= W_IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            lcd_e  <= 1'b0;
            lcd_rs <= 1'b0;
            lcd_db <= '0;
        end else begin
            done <= 1'b0;
            case (phase)
                W_IDLE: if (start) begin
                    lcd_rs <= rs;
                    lcd_db <= nibble;
                    cnt    <= 32'(SETUP_CYC - 1);
                    phase  <= W_SETUP;
                end
                W_SETUP: if (cnt == '0) begin
                    lcd_e <= 1'b1;
                    cnt   <= 32'(E_PULSE_CYC - 1);
                    phase <= W_PULSE;
                end else begin
                    cnt <= cnt - 32'd1;
                end
                W_PULSE: if (cnt == '0) begin
                    lcd_e <= 1'b0;
                    cnt   <= post_wait - 32'(HANDSHAKE_CYC + 1);
                    phase <= W_HOLD;
                end else begin
                    cnt <= cnt - 32'd1;
                end
                W_HOLD: if (cnt == '0) begin
                    done  <= 1'b1;
                    phase <= W_IDLE;
                end else begin
                    cnt <= cnt - 32'd1;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_text_driver.sv
// rtl/lcd_text_driver.sv - HD44780 16x2 4-bit driver: power-up init, then endless two-line refresh
// Frame = 34*(2*(SETUP_CYC+E_PULSE_CYC)+NIBBLE_GAP_CYC+CMD_WAIT_CYC) + 2 cycles (FRAME_END and LATCH).
module lcd_text_driver
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC    = 750000,
    parameter int INIT_LONG_CYC  = 205000,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int NIBBLE_GAP_CYC = 50,
    parameter int SETUP_CYC      = 2,
    parameter int E_PULSE_CYC    = 12
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic [TEXT_W-1:0] textIn,
    output logic [3:0]        LCD_DB,
    output logic              LCD_E,
    output logic              LCD_RS,
    output logic              LCD_RW,
    output logic              init_done,
    output logic              frame_done
);

    lcd_state_t   state;
    logic [31:0]  cnt;
    logic [2:0]   step;
    logic [4:0]   idx;
    logic         lo, busy, start, nib_rs, wr_done;
    logic [3:0]   nib_val;
    logic [31:0]  nib_wait;
    logic [255:0] snap;
    logic         text_unused;

    logic         slot_rs, single;
    logic [7:0]   slot_byte;
    logic [3:0]   slot_nib;
    logic [31:0]  slot_wait;

    assign LCD_RW      = 1'b0;
    assign text_unused = textIn[TEXT_W-1];

    // The nibble the FSM would issue next, derived from where it is in the sequence
    always_comb begin
        slot_rs   = 1'b0;
        slot_byte = 8'h00;
        single    = 1'b0;
        case (state)
            INIT: if (!step[2]) begin
                single    = 1'b1;
                slot_byte = (step == 3'd3) ? 8'h02 : 8'h03;
            end else begin
                slot_byte = init_cmd(step[1:0]);
            end
            ADDR1:        slot_byte = LCD_LINE1;
            ADDR2:        slot_byte = LCD_LINE2;
            LINE1, LINE2: begin
                slot_rs   = 1'b1;
                slot_byte = char_at(snap, idx);
            end
            default: ;
        endcase
        slot_nib = (single || lo) ? slot_byte[3:0] : slot_byte[7:4];
        if (single)
            slot_wait = (step < 3'd2) ? 32'(INIT_LONG_CYC) : 32'(CMD_WAIT_CYC);
        else if (!lo)
            slot_wait = 32'(NIBBLE_GAP_CYC);
        else if (!slot_rs && slot_byte == LCD_CLEAR)
            slot_wait = 32'(CLEAR_WAIT_CYC);
        else
            slot_wait = 32'(CMD_WAIT_CYC);
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= POWERUP;
            cnt        <= '0;
            step       <= '0;
            idx        <= '0;
            lo         <= 1'b0;
            busy       <= 1'b0;
            start      <= 1'b0;
            nib_rs     <= 1'b0;
            nib_val    <= '0;
            nib_wait   <= '0;
            snap       <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            start      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                POWERUP: if (cnt == 32'(POWERUP_CYC - HANDSHAKE_CYC)) state <= INIT;
                         else cnt <= cnt + 32'd1;
                LATCH: begin
                    snap  <= textIn[255:0];
                    state <= ADDR1;
                end
                FRAME_END: begin
                    frame_done <= 1'b1;
                    state      <= LATCH;
                end
                INIT, ADDR1, LINE1, ADDR2, LINE2:
                    if (!busy) begin
                        start    <= 1'b1;
                        busy     <= 1'b1;
                        nib_rs   <= slot_rs;
                        nib_val  <= slot_nib;
                        nib_wait <= slot_wait;
                    end else if (wr_done) begin
                        busy <= 1'b0;
                        if (!single && !lo) begin
                            lo <= 1'b1;
                        end else begin
                            lo <= 1'b0;
                            case (state)
                                INIT: if (step == 3'd7) begin
                                    init_done <= 1'b1;
                                    state     <= LATCH;
                                end else begin
                                    step <= step + 3'd1;
                                end
                                ADDR1: state <= LINE1;
                                LINE1: begin
                                    idx <= idx + 5'd1;
                                    if (idx == 5'd15) state <= ADDR2;
                                end
                                ADDR2: state <= LINE2;
                                LINE2: begin
                                    idx <= idx + 5'd1;
                                    if (idx == 5'd31) state <= FRAME_END;
                                end
                                default: ;
                            endcase
                        end
                    end
                default: state <= POWERUP;
            endcase
        end
    end

    lcd_nibble_writer #(
        .SETUP_CYC   (SETUP_CYC),
        .E_PULSE_CYC (E_PULSE_CYC)
    ) u_writer (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .start     (start),
        .rs        (nib_rs),
        .nibble    (nib_val),
        .post_wait (nib_wait),
        .done      (wr_done),
        .lcd_e     (LCD_E),
        .lcd_rs    (LCD_RS),
        .lcd_db    (LCD_DB)
    );

endmodule

// File: doc/lcd_text_driver.md
# lcd_text_driver

Drives a 16x2 HD44780-compatible character LCD in 4-bit mode from the 32-character `textOut` bus that every calculator function module produces. It runs the power-up initialisation once, then loops: it snapshots the text bus and writes line 1 (chars 0–15) and line 2 (chars 16–31). It sits between the function-select mux and the board LCD pins, and is the only block that touches them.

## Interface
Parameters (cycle counts; defaults for 50 MHz):
- `POWERUP_CYC`, 750000, wait after reset before the first nibble (15 ms)
- `INIT_LONG_CYC`, 205000, wait after each of the first two init nibbles (4.1 ms)
- `CLEAR_WAIT_CYC`, 82000, wait after the Clear byte (1.64 ms)
- `CMD_WAIT_CYC`, 2000, wait after any other byte, and after the third init nibble (40 us)
- `NIBBLE_GAP_CYC`, 50, wait between the high-nibble and low-nibble writes of one byte (1 us)
- `SETUP_CYC`, 2, cycles that RS/DB are stable before E rises
- `E_PULSE_CYC`, 12, E high width

Ports:
- `Clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `textIn`  in  257  ASCII text. Char k (0..31) is at `textIn[255-8k -: 8]`. Bit 256 is ignored.
- `LCD_DB`  out  4  LCD data nibble (DB7..DB4)
- `LCD_E`  out  1  LCD enable strobe
- `LCD_RS`  out  1  0 = command, 1 = data
- `LCD_RW`  out  1  tied 0 (write-only)
- `init_done`  out  1  high once initialisation completes; stays high until reset
- `frame_done`  out  1  one-cycle pulse after the last byte of each frame and its wait

## Operation
- Reset (async, `reset_n`=0): all outputs 0; FSM in `POWERUP`; counters cleared. Release restarts the full power-up sequence.
- Nibble write (sub-module): drive RS/DB. After `SETUP_CYC` cycles, E=1 for `E_PULSE_CYC` cycles, then E=0. Then hold RS/DB for the post-wait requested by the caller, then assert `done` for one cycle.
- Byte write: high nibble, post-wait `NIBBLE_GAP_CYC`; then low nibble, post-wait `CMD_WAIT_CYC`, or `CLEAR_WAIT_CYC` for byte 0x01.
- Top FSM states:
  - `POWERUP`: wait `POWERUP_CYC`, then `INIT`.
  - `INIT`: RS=0 single nibbles 0x3 (`INIT_LONG`), 0x3 (`INIT_LONG`), 0x3 (`CMD_WAIT`), 0x2 (`CMD_WAIT`). Then RS=0 bytes 0x28, 0x06, 0x0C, 0x01. Then set `init_done`.
  - `LATCH`: copy `textIn` into a 256-bit snapshot register.
  - `ADDR1`: byte 0x80, RS=0.
  - `LINE1`: chars 0..15, RS=1.
  - `ADDR2`: byte 0xC0, RS=0.
  - `LINE2`: chars 16..31, RS=1.
  - `FRAME_END`: pulse `frame_done`, return to `LATCH`.
- The character index counter is 5 bits and counts 0..31. `LINE1` leaves at index 15→16. `LINE2` leaves at index 31, and the counter wraps to 0.
- Any byte value is sent verbatim; there is no filtering of non-printables.
- `textIn` changes during a frame do not affect that frame. They appear in the next frame.

## Timing
- First E rise occurs `POWERUP_CYC + SETUP_CYC` cycles after `reset_n` rises, within ±1 cycle.
- Between consecutive E pulses, E is low for at least post-wait + `SETUP_CYC` cycles.
- DB/RS change only while E=0. They never change within `SETUP_CYC` cycles before E rises or while E=1.
- Frame length in cycles is 34 × (2·(`SETUP_CYC`+`E_PULSE_CYC`) + `NIBBLE_GAP_CYC` + `CMD_WAIT_CYC`) plus a small constant FSM overhead. The overhead is a fixed number of cycles, stated in the RTL header.
- `frame_done` fires once per frame, and never before `init_done`.

## Structure
- Shared package `lcd_pkg`:
  - command constants: `LCD_FUNC_SET`=0x28, `LCD_ENTRY`=0x06, `LCD_DISP_ON`=0x0C, `LCD_CLEAR`=0x01, `LCD_LINE1`=0x80, `LCD_LINE2`=0xC0
  - the `TEXT_W`=257 constant
  - the top-FSM state encoding (one-hot, matching the other calculator FSMs)
- One sub-module, `lcd_nibble_writer`:
  - inputs: `start`, `rs`, `nibble`, `post_wait`
  - outputs: `done`, plus the pin drives
  - owns the setup/pulse/wait counter

## Test plan
Parameters for all runs: `POWERUP_CYC`=100, `INIT_LONG_CYC`=40, `CLEAR_WAIT_CYC`=64, `CMD_WAIT_CYC`=16, `NIBBLE_GAP_CYC`=8, `SETUP_CYC`=2, `E_PULSE_CYC`=4.
1. Reset held, then released. Required: all outputs 0 while held; no E edge for 100 cycles after release; first E rise at cycle 102 after release.
2. Capture (RS, DB) on each E fall through init. Required: RS=0 nibbles 3,3,3,2,2,8,0,6,0,C,0,1; `init_done` rises after the 64-cycle clear wait.
3. `textIn` = "Division        Divides 2 Nums  ". Required decoded bytes: 0x80, 0x44 'D', 0x69 ... (16 chars), 0xC0, 0x44 ... 0x20; then a `frame_done` pulse; then the sequence repeats.
4. Change `textIn` to "Input 1st #     Then Press Btnc " mid-LINE1. Required: the current frame completes with the old text; the next frame carries the new text.
5. Protocol checker on every nibble. Required: E high exactly 4 cycles; DB/RS stable ≥2 cycles before E rise and throughout E high; high→low nibble gap = 8+2 cycles.
6. Assert `reset_n`=0 during LINE2. Required: outputs go to 0 asynchronously in the same cycle; `init_done`=0; on release the full power-up and init sequence repeats.
